// File: rtl/dac_stream_pacer.sv
// dac_stream_pacer
//   Absorbs a backpressure-free 32-bit word stream into a word FIFO, splits
//   each word into two 16-bit DAC samples (low half first) and releases them
//   at a fixed, programmable rate. Flags dropped words and starvation.
//
// Ports
//   clk, rst_n        clock, async active-low reset
//   enable            level-sensitive playback enable; low flushes to IDLE
//   rate_div          cycles per output sample (0 behaves as 1)
//   in_t_data/valid   input word stream, no ready
//   clr_flags         pulse clearing ovf_sticky and unf_count
//   dac_data          registered DAC sample
//   dac_strobe        one-cycle pulse with each dac_data update
//   fifo_level        FIFO occupancy in words
//   running           high while playing
//   ovf_sticky        a word was dropped because the FIFO was full
//   unf_count         saturating count of starvation events
module dac_stream_pacer #(
   parameter int          DEPTH       = 16,
   parameter int          PRIME_LEVEL = 8,
   parameter logic [15:0] IDLE_CODE   = 16'h0000
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     enable,
   input  logic [15:0]              rate_div,
   input  logic [31:0]              in_t_data,
   input  logic                     in_t_valid,
   input  logic                     clr_flags,
   output logic [15:0]              dac_data,
   output logic                     dac_strobe,
   output logic [$clog2(DEPTH):0]   fifo_level,
   output logic                     running,
   output logic                     ovf_sticky,
   output logic [15:0]              unf_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   typedef enum logic [1:0] {S_IDLE, S_PRIME, S_RUN} state_t;

   state_t          state;
   logic [31:0]     mem [DEPTH];
   logic [AW-1:0]   rd_ptr, wr_ptr;
   logic [15:0]     pace_cnt;
   logic            half;
   logic [15:0]     hi_reg;

   logic [15:0]     eff_last;
   logic            active, tick, fifo_empty, fifo_full;
   logic            do_pop, do_push, underflow, drop;
   logic [31:0]     popped;
   logic [15:0]     unf_inc;

   assign eff_last   = (rate_div > 16'd1) ? rate_div - 16'd1 : 16'd0;
   assign active     = enable && (state != S_IDLE);
   // ">=" rather than "==" so a rate_div reduced mid-run wraps at once
   // instead of counting all the way round 16 bits.
   assign tick       = enable && (state == S_RUN) && (pace_cnt >= eff_last);
   assign fifo_empty = (fifo_level == '0);
   assign fifo_full  = (fifo_level == LW'(DEPTH));
   assign do_pop     = tick && !half && !fifo_empty;
   assign underflow  = tick && !half && fifo_empty;
   // A pop in the same cycle frees the slot, so a full FIFO still accepts.
   assign do_push    = active && in_t_valid && (!fifo_full || do_pop);
   assign drop       = active && in_t_valid && fifo_full && !do_pop;
   assign popped     = mem[rd_ptr];
   assign unf_inc    = (unf_count == 16'hFFFF) ? unf_count : unf_count + 16'd1;
   assign running    = (state == S_RUN);

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= in_t_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         fifo_level <= '0;
         pace_cnt   <= '0;
         half       <= 1'b0;
         hi_reg     <= '0;
         dac_data   <= IDLE_CODE;
         dac_strobe <= 1'b0;
         ovf_sticky <= 1'b0;
         unf_count  <= '0;
      end else begin
         dac_strobe <= 1'b0;

         // Events beat a coincident clear.
         if (drop)           ovf_sticky <= 1'b1;
         else if (clr_flags) ovf_sticky <= 1'b0;
         if (underflow)      unf_count  <= clr_flags ? 16'd1 : unf_inc;
         else if (clr_flags) unf_count  <= '0;

         if (!enable) begin
            state      <= S_IDLE;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_level <= '0;
            pace_cnt   <= '0;
            half       <= 1'b0;
            dac_data   <= IDLE_CODE;
         end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            unique case ({do_push, do_pop})
               2'b10:   fifo_level <= fifo_level + LW'(1);
               2'b01:   fifo_level <= fifo_level - LW'(1);
               default: ;
            endcase

            case (state)
               S_IDLE: state <= S_PRIME;
               S_PRIME: begin
                  if (int'(fifo_level) >= PRIME_LEVEL) begin
                     state    <= S_RUN;
                     pace_cnt <= '0;
                     half     <= 1'b0;
                  end
               end
               S_RUN: begin
                  pace_cnt <= tick ? 16'd0 : pace_cnt + 16'd1;
                  if (tick) begin
                     dac_strobe <= 1'b1;
                     if (half) begin
                        dac_data <= hi_reg;
                        half     <= 1'b0;
                     end else if (!fifo_empty) begin
                        dac_data <= popped[15:0];
                        hi_reg   <= popped[31:16];
                        half     <= 1'b1;
                     end else begin
                        // Starved: emit the idle code once and re-prime.
                        dac_data <= IDLE_CODE;
                        state    <= S_PRIME;
                     end
                  end
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_dac_stream_pacer.sv
// Directed bench for dac_stream_pacer with a sample scoreboard: expected
// samples are queued as words are driven and checked on every strobe.
module tb_dac_stream_pacer;

   localparam int          LW        = 5;
   localparam logic [15:0] IDLE_CODE = 16'h0000;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          enable = 1'b0;
   logic [15:0]   rate_div = 16'd1;
   logic [31:0]   in_t_data = '0;
   logic          in_t_valid = 1'b0;
   logic          clr_flags = 1'b0;
   logic [15:0]   dac_data;
   logic          dac_strobe;
   logic [LW-1:0] fifo_level;
   logic          running;
   logic          ovf_sticky;
   logic [15:0]   unf_count;

   int          n_run = 0, n_fail = 0;
   int          strobe_cnt = 0, cyc = 0, last_strobe = -1, exp_gap = 0;
   bit          gap_chk = 1'b0;
   int          base;
   logic [15:0] exp_q[$];

   always #5 clk = ~clk;

   dac_stream_pacer #(.DEPTH(16), .PRIME_LEVEL(8), .IDLE_CODE(IDLE_CODE)) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .rate_div(rate_div),
      .in_t_data(in_t_data), .in_t_valid(in_t_valid), .clr_flags(clr_flags),
      .dac_data(dac_data), .dac_strobe(dac_strobe), .fifo_level(fifo_level),
      .running(running), .ovf_sticky(ovf_sticky), .unf_count(unf_count)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_run++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // Scoreboard consumer and strobe spacing monitor.
   always @(negedge clk) begin
      cyc++;
      if (rst_n && dac_strobe) begin
         strobe_cnt++;
         check("sb_has_expected", 32'(exp_q.size() > 0), 32'd1);
         if (exp_q.size() > 0) check("dac_sample", 32'(dac_data), 32'(exp_q.pop_front()));
         if (gap_chk && last_strobe >= 0) check("strobe_gap", 32'(cyc - last_strobe), 32'(exp_gap));
         last_strobe = cyc;
      end
   end

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic push_word(input logic [31:0] w, input bit queued);
      in_t_data  = w;
      in_t_valid = 1'b1;
      if (queued) begin
         exp_q.push_back(w[15:0]);
         exp_q.push_back(w[31:16]);
      end
      step();
      in_t_valid = 1'b0;
   endtask

   task automatic wait_until(input int tgt, input int budget);
      for (int i = 0; i < budget && strobe_cnt < tgt; i++) begin
         @(negedge clk); #1;
      end
      check("strobe_count", 32'(strobe_cnt), 32'(tgt));
   endtask

   initial begin
      // Reset state
      #12;
      check("rst_dac_data", 32'(dac_data), 32'(IDLE_CODE));
      check("rst_strobe", 32'(dac_strobe), 32'd0);
      check("rst_level", 32'(fifo_level), 32'd0);
      check("rst_running", 32'(running), 32'd0);
      check("rst_ovf", 32'(ovf_sticky), 32'd0);
      check("rst_unf", 32'(unf_count), 32'd0);
      rst_n = 1'b1;
      step();

      // 1: rate_div=1, eight words, back-to-back samples then starvation
      enable = 1'b1;
      step();
      base = strobe_cnt;
      for (int k = 0; k < 8; k++) push_word({16'(2*k+1), 16'(2*k)}, 1'b1);
      exp_q.push_back(IDLE_CODE);
      check("t1_primed_level", 32'(fifo_level), 32'd8);
      check("t1_not_yet_running", 32'(running), 32'd0);
      step();
      check("t1_running", 32'(running), 32'd1);
      check("t1_level_a", 32'(fifo_level), 32'd8);
      step();
      check("t1_level_b", 32'(fifo_level), 32'd7);
      check("t1_first_sample", 32'(dac_data), 32'd0);
      step();
      check("t1_level_c", 32'(fifo_level), 32'd7);
      step();
      check("t1_level_d", 32'(fifo_level), 32'd6);
      wait_until(base + 17, 60);
      check("t1_unf", 32'(unf_count), 32'd1);
      check("t1_reprime", 32'(running), 32'd0);
      clr_flags = 1'b1;
      step();
      clr_flags = 1'b0;
      check("t1_clr_unf", 32'(unf_count), 32'd0);

      // 2: rate_div=4, strobes exactly four cycles apart, then underflow
      rate_div    = 16'd4;
      last_strobe = -1;
      exp_gap     = 4;
      gap_chk     = 1'b1;
      base        = strobe_cnt;
      for (int k = 0; k < 8; k++) push_word({16'h2000 + 16'(2*k+1), 16'h2000 + 16'(2*k)}, 1'b1);
      exp_q.push_back(IDLE_CODE);
      wait_until(base + 17, 200);
      gap_chk = 1'b0;
      check("t2_unf", 32'(unf_count), 32'd1);
      check("t2_reprime", 32'(running), 32'd0);

      // 3: stalled playback, 20-word burst overflows the 16-deep FIFO
      rate_div = 16'hFFFF;
      for (int k = 0; k < 20; k++) begin
         push_word({16'h3000 + 16'(2*k+1), 16'h3000 + 16'(2*k)}, k < 16);
         if (k == 15) begin
            check("t3_full_level", 32'(fifo_level), 32'd16);
            check("t3_no_ovf_yet", 32'(ovf_sticky), 32'd0);
         end
      end
      check("t3_level", 32'(fifo_level), 32'd16);
      check("t3_ovf", 32'(ovf_sticky), 32'd1);
      check("t3_running", 32'(running), 32'd1);

      // 4: full FIFO, word arrives on a popping tick -> accepted
      clr_flags = 1'b1;
      step();
      clr_flags = 1'b0;
      check("t4_ovf_cleared", 32'(ovf_sticky), 32'd0);
      rate_div = 16'd1;
      push_word(32'h3FFF_3FFE, 1'b1);
      check("t4_level", 32'(fifo_level), 32'd16);
      check("t4_ovf", 32'(ovf_sticky), 32'd0);
      check("t4_first_pop", 32'(dac_data), 32'h3000);

      // 5: one-cycle disable mid-playback flushes; re-prime from fresh data
      wait_until(strobe_cnt + 10, 40);
      enable     = 1'b0;
      in_t_valid = 1'b1;
      in_t_data  = 32'hDEAD_BEEF;
      step();
      exp_q.delete();
      check("t5_dac_idle", 32'(dac_data), 32'(IDLE_CODE));
      check("t5_no_strobe", 32'(dac_strobe), 32'd0);
      check("t5_level", 32'(fifo_level), 32'd0);
      check("t5_running", 32'(running), 32'd0);
      check("t5_ovf_kept", 32'(ovf_sticky), 32'd0);
      enable = 1'b1;
      step();
      in_t_valid = 1'b0;
      for (int k = 0; k < 8; k++) push_word({16'h4000 + 16'(2*k+1), 16'h4000 + 16'(2*k)}, 1'b1);
      check("t5_fresh_level", 32'(fifo_level), 32'd8);
      wait_until(strobe_cnt + 5, 40);

      // 6: asynchronous reset between edges mid-run
      #2;
      rst_n = 1'b0;
      #1;
      exp_q.delete();
      check("t6_rst_dac", 32'(dac_data), 32'(IDLE_CODE));
      check("t6_rst_strobe", 32'(dac_strobe), 32'd0);
      check("t6_rst_level", 32'(fifo_level), 32'd0);
      check("t6_rst_running", 32'(running), 32'd0);
      #3;
      rst_n = 1'b1;
      step();

      // 6b: clr_flags coincident with an underflow -> count is 1
      rate_div = 16'd1;
      for (int k = 0; k < 8; k++) push_word({16'h5000 + 16'(2*k+1), 16'h5000 + 16'(2*k)}, 1'b1);
      exp_q.push_back(IDLE_CODE);
      base = strobe_cnt;
      wait_until(base + 16, 60);
      clr_flags = 1'b1;
      step();
      clr_flags = 1'b0;
      check("t6_unf_event_wins", 32'(unf_count), 32'd1);
      check("t6_unf_strobe", 32'(dac_strobe), 32'd1);
      check("t6_reprime", 32'(running), 32'd0);
      wait_until(base + 17, 5);
      check("sb_drained", 32'(exp_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
